// File: rtl/bcd_stopwatch4_pkg.sv
// Shared definitions for the stopwatch and the display-path blocks it feeds:
// FSM state encodings and the largest legal BCD digit value.
package bcd_stopwatch4_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_stopwatch4_digit.sv
// One BCD decade: counts 0..9 on inc and passes a carry to the next decade
// in the same cycle that it wraps 9 -> 0.
module bcd_digit
  import bcd_stopwatch4_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry_out
);

  assign carry_out = inc && (q == BCD_MAX);

  // NOTE: sequential state uses non-blocking assignments so every decade samples its neighbour's pre-edge value.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_stopwatch4.sv
// Four-digit BCD stopwatch: start/stop button FSM, tick prescaler and a
// cascade of four BCD decades with a sticky overflow flag.
module bcd_stopwatch4
  import bcd_stopwatch4_pkg::*;
#(
  parameter int TICK_DIV = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       overflow
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic          start_stop_q;
  logic          press;
  logic          tick;
  logic [3:0]    carry;

  assign press = start_stop & ~start_stop_q;
  assign tick  = (state == RUN) && (presc == PRESC_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      running      <= 1'b0;
      presc        <= '0;
      overflow     <= 1'b0;
      // NOTE: resets to 1 so a button held through reset is not seen as a press.
      start_stop_q <= 1'b1;
    end else begin
      start_stop_q <= start_stop;
      if (clear) begin
        state    <= IDLE;
        running  <= 1'b0;
        presc    <= '0;
        overflow <= 1'b0;
      end else begin
        case (state)
          IDLE:    if (press) begin state <= RUN;   running <= 1'b1; end
          RUN:     if (press) begin state <= PAUSE; running <= 1'b0; end
          PAUSE:   if (press) begin state <= RUN;   running <= 1'b1; end
          default: begin state <= IDLE; running <= 1'b0; end
        endcase

        // Prescaler phase survives PAUSE so resumed timing stays exact.
        if (state == RUN) begin
          presc <= tick ? '0 : presc + 1'b1;
        end else if (state == IDLE) begin
          presc <= '0;
        end

        if (carry[3]) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  bcd_digit u_digit0 (.clock(clock), .reset(reset), .clr(clear), .inc(tick),
                      .q(digit0), .carry_out(carry[0]));
  bcd_digit u_digit1 (.clock(clock), .reset(reset), .clr(clear), .inc(carry[0]),
                      .q(digit1), .carry_out(carry[1]));
  bcd_digit u_digit2 (.clock(clock), .reset(reset), .clr(clear), .inc(carry[1]),
                      .q(digit2), .carry_out(carry[2]));
  bcd_digit u_digit3 (.clock(clock), .reset(reset), .clr(clear), .inc(carry[2]),
                      .q(digit3), .carry_out(carry[3]));

endmodule

// File: tb/tb_bcd_stopwatch4.sv
// Directed bench for bcd_stopwatch4 with TICK_DIV = 4: expected outputs are
// queued as stimulus is applied and compared on the following falling edge.
module tb_bcd_stopwatch4;

  logic       clock;
  logic       reset;
  logic       start_stop;
  logic       clear;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       running;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [15:0] digits;
    logic       run;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  bcd_stopwatch4 #(.TICK_DIV(4)) dut (
    .clock(clock),
    .reset(reset),
    .start_stop(start_stop),
    .clear(clear),
    .digit0(digit0),
    .digit1(digit1),
    .digit2(digit2),
    .digit3(digit3),
    .running(running),
    .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_out(input string tag, input logic [15:0] d,
                            input logic r, input logic o);
    exp_t e;
    e.tag = tag; e.digits = d; e.run = r; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [17:0] obs;
    logic [17:0] req;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard: no expected entry queued");
      return;
    end
    e   = sb.pop_front();
    obs = {digit3, digit2, digit1, digit0, running, overflow};
    req = {e.digits, e.run, e.ovf};
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s: observed digits=%h running=%b overflow=%b, expected digits=%h running=%b overflow=%b",
             e.tag, obs[17:2], obs[1], obs[0], req[17:2], req[1], req[0]);
    end
  endtask

  initial begin
    reset = 1'b1; start_stop = 1'b1; clear = 1'b0;

    // Reset held three cycles with the button held.
    expect_out("reset_hold", 16'h0000, 1'b0, 1'b0);
    cyc(3); check();
    reset = 1'b0;
    expect_out("reset_release_no_press", 16'h0000, 1'b0, 1'b0);
    cyc(5); check();
    start_stop = 1'b0;
    cyc(1);

    // Basic count: first tick lands TICK_DIV edges after the press.
    start_stop = 1'b1;
    expect_out("press_to_run", 16'h0000, 1'b1, 1'b0);
    cyc(1); check();
    expect_out("before_first_tick", 16'h0000, 1'b1, 1'b0);
    cyc(3); check();
    start_stop = 1'b0;
    expect_out("first_tick", 16'h0001, 1'b1, 1'b0);
    cyc(1); check();
    expect_out("count_40_cycles", 16'h0010, 1'b1, 1'b0);
    cyc(36); check();

    // Clear from RUN back to IDLE.
    clear = 1'b1;
    expect_out("clear_in_run", 16'h0000, 1'b0, 1'b0);
    cyc(1); check();
    clear = 1'b0;

    // Pause at 0003 with prescaler phase 2, then resume.
    start_stop = 1'b1;
    expect_out("pause_start", 16'h0000, 1'b1, 1'b0);
    cyc(1); check();
    start_stop = 1'b0;
    expect_out("reach_0003", 16'h0003, 1'b1, 1'b0);
    cyc(12); check();
    cyc(1);
    start_stop = 1'b1;
    expect_out("pause_entered", 16'h0003, 1'b0, 1'b0);
    cyc(1); check();
    start_stop = 1'b0;
    expect_out("pause_hold_20", 16'h0003, 1'b0, 1'b0);
    cyc(20); check();
    start_stop = 1'b1;
    expect_out("resume", 16'h0003, 1'b1, 1'b0);
    cyc(1); check();
    expect_out("resume_tick_pending", 16'h0003, 1'b1, 1'b0);
    cyc(1); check();
    expect_out("resume_phase_kept", 16'h0004, 1'b1, 1'b0);
    cyc(1); check();
    start_stop = 1'b0;

    // Wrap 9999 -> 0000 with sticky overflow.
    clear = 1'b1;
    expect_out("clear_before_wrap", 16'h0000, 1'b0, 1'b0);
    cyc(1); check();
    clear = 1'b0;
    start_stop = 1'b1;
    expect_out("wrap_run", 16'h0000, 1'b1, 1'b0);
    cyc(1); check();
    start_stop = 1'b0;
    expect_out("at_9999", 16'h9999, 1'b1, 1'b0);
    cyc(39996); check();
    expect_out("wrap_0000", 16'h0000, 1'b1, 1'b1);
    cyc(4); check();
    expect_out("overflow_sticky", 16'h0001, 1'b1, 1'b1);
    cyc(4); check();

    // Clear and press together: clear wins, press dropped.
    clear = 1'b1; start_stop = 1'b1;
    expect_out("clear_with_press", 16'h0000, 1'b0, 1'b0);
    cyc(1); check();
    clear = 1'b0;
    expect_out("held_press_ignored", 16'h0000, 1'b0, 1'b0);
    cyc(5); check();

    // Reset mid-RUN at 0057 aborts counting.
    start_stop = 1'b0;
    cyc(1);
    start_stop = 1'b1;
    expect_out("run_before_reset", 16'h0000, 1'b1, 1'b0);
    cyc(1); check();
    start_stop = 1'b0;
    expect_out("at_0057", 16'h0057, 1'b1, 1'b0);
    cyc(228); check();
    reset = 1'b1;
    expect_out("reset_in_run", 16'h0000, 1'b0, 1'b0);
    cyc(1); check();
    reset = 1'b0;
    expect_out("no_tick_after_reset", 16'h0000, 1'b0, 1'b0);
    cyc(10); check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
